// File: rtl/freq_count_latch_if.sv
// Signal bundle for the frequency counter: the gate/latch controls and
// prescale select going in, and the latched BCD result coming out.
interface freq_count_latch_if;
  logic        sigIn;
  logic        enable;
  logic        clear;
  logic        latch;
  logic [1:0]  testMode;
  logic [15:0] bcdOut;
  logic        overflow;
  logic        dataValid;
  logic [1:0]  state;

  // Driver side (the environment that controls the counter)
  modport master (
    output sigIn, enable, clear, latch, testMode,
    input  bcdOut, overflow, dataValid, state
  );

  // Counter side
  modport slave (
    input  sigIn, enable, clear, latch, testMode,
    output bcdOut, overflow, dataValid, state
  );
endinterface

// File: rtl/freq_count_latch.sv
// Gated frequency counter: synchronises sigIn, divides its rising edges by a
// decade prescaler and accumulates them in a saturating 4-digit BCD counter.
// A rising edge on latch snapshots the running count and overflow flag.
module freq_count_latch (
  input  logic                 clkControl,
  input  logic                 reset,
  freq_count_latch_if.slave    fc
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    HOLD     = 2'b10
  } stateT;

  stateT       stateReg, stateNext;
  logic [2:0]  syncReg;
  logic        sigEdge;
  logic [9:0]  prescReg;
  logic [9:0]  termCount;
  logic [1:0]  testModeReg;
  logic        modeChange;
  logic [15:0] countReg;
  logic [15:0] countInc;
  logic        ovfFlagReg;
  logic        latchReg;
  logic        latchRise;
  logic        countEn;
  logic [4:0]  carry;
  logic [15:0] bcdOutReg;
  logic        overflowReg;
  logic        dataValidReg;

  // Two-flop synchroniser plus a third stage for rising-edge detection
  always_ff @(posedge clkControl) begin
    if (reset) syncReg <= 3'b000;
    else       syncReg <= {syncReg[1:0], fc.sigIn};
  end

  assign sigEdge    = syncReg[1] & ~syncReg[2];
  assign modeChange = (fc.testMode != testModeReg);
  assign latchRise  = fc.latch & ~latchReg;
  assign countEn    = (stateReg == COUNTING) && sigEdge && !fc.clear;

  // Prescaler terminal value (count - 1) selected by testMode
  always_comb begin
    termCount = 10'd0;
    case (fc.testMode)
      2'b00: termCount = 10'd0;
      2'b01: termCount = 10'd9;
      2'b10: termCount = 10'd99;
      2'b11: termCount = 10'd999;
      default: termCount = 10'd0;
    endcase
  end

  // BCD ripple increment; carry[4] doubles as the "all nines" indicator
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gDigit
      logic [3:0] digit;
      assign digit          = countReg[gi*4 +: 4];
      assign carry[gi+1]    = carry[gi] && (digit == 4'd9);
      assign countInc[gi*4 +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                                             : digit;
    end
  endgenerate

  // Remember the previous prescale select and latch level for change detection
  always_ff @(posedge clkControl) begin
    if (reset) begin
      testModeReg <= 2'b00;
      latchReg    <= 1'b0;
    end else begin
      testModeReg <= fc.testMode;
      latchReg    <= fc.latch;
    end
  end

  // Prescaler, running BCD count and sticky overflow; clear wins over counting
  always_ff @(posedge clkControl) begin
    if (reset || fc.clear) begin
      prescReg   <= 10'd0;
      countReg   <= 16'h0000;
      ovfFlagReg <= 1'b0;
    end else if (modeChange) begin
      // Switching range restarts the prescaler but keeps the running count
      prescReg <= 10'd0;
    end else if (countEn) begin
      if (prescReg == termCount) begin
        prescReg <= 10'd0;
        if (carry[4]) ovfFlagReg <= 1'b1;
        else          countReg   <= countInc;
      end else begin
        prescReg <= prescReg + 10'd1;
      end
    end
  end

  // Output snapshot on a latch rise; sees pre-edge count even with clear/increment
  always_ff @(posedge clkControl) begin
    if (reset) begin
      bcdOutReg    <= 16'h0000;
      overflowReg  <= 1'b0;
      dataValidReg <= 1'b0;
    end else begin
      dataValidReg <= latchRise;
      if (latchRise) begin
        bcdOutReg   <= countReg;
        overflowReg <= ovfFlagReg;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clkControl) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // FSM next-state: enable gates counting, clear always returns to IDLE
  always_comb begin
    stateNext = stateReg;
    if (fc.clear) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE:     if (fc.enable)  stateNext = COUNTING;
        COUNTING: if (!fc.enable) stateNext = HOLD;
        HOLD:     if (fc.enable)  stateNext = COUNTING;
        default:  stateNext = IDLE;
      endcase
    end
  end

  assign fc.bcdOut    = bcdOutReg;
  assign fc.overflow  = overflowReg;
  assign fc.dataValid = dataValidReg;
  assign fc.state     = stateReg;

endmodule

// File: tb/tb_freq_count_latch.sv
// Directed bench for freq_count_latch: a table of count/latch scenarios plus
// hand-written sequences for simultaneous clear/latch, hold and reset.
module tb_freq_count_latch;

  logic clkControl = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  freq_count_latch_if fcIf ();

  freq_count_latch dut (
    .clkControl (clkControl),
    .reset      (reset),
    .fc         (fcIf)
  );

  always #5 clkControl = ~clkControl;

  typedef struct {
    logic        doClear;
    logic [1:0]  mode;
    int          pulses;
    int          halfPer;
    logic [15:0] expBcd;
    logic        expOvf;
  } vecT;

  vecT vecs [7];

  task automatic tick(input int n);
    repeat (n) @(negedge clkControl);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulses(input int n, input int hp);
    for (int i = 0; i < n; i++) begin
      fcIf.sigIn = 1'b1;
      tick(hp);
      fcIf.sigIn = 1'b0;
      tick(hp);
    end
  endtask

  // Raise latch, hold it for holdCycles, and report how many dataValid pulses appeared
  task automatic doLatch(input int holdCycles, output int dvCount);
    dvCount = 0;
    fcIf.latch = 1'b1;
    for (int i = 0; i < holdCycles; i++) begin
      tick(1);
      if (fcIf.dataValid) dvCount++;
    end
    fcIf.latch = 1'b0;
    tick(1);
    if (fcIf.dataValid) dvCount++;
  endtask

  task automatic doClear();
    fcIf.clear = 1'b1;
    tick(1);
    fcIf.clear = 1'b0;
  endtask

  int dv;

  initial begin
    vecs[0] = '{1'b1, 2'b00,    37, 4, 16'h0037, 1'b0};
    vecs[1] = '{1'b1, 2'b01,  1234, 1, 16'h0123, 1'b0};
    vecs[2] = '{1'b0, 2'b01,     6, 4, 16'h0124, 1'b0};
    vecs[3] = '{1'b1, 2'b10,   250, 1, 16'h0002, 1'b0};
    vecs[4] = '{1'b0, 2'b11,  1000, 1, 16'h0003, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 10005, 1, 16'h9999, 1'b1};
    vecs[6] = '{1'b1, 2'b00,     0, 1, 16'h0000, 1'b0};

    fcIf.sigIn = 1'b0; fcIf.enable = 1'b0; fcIf.clear = 1'b0;
    fcIf.latch = 1'b0; fcIf.testMode = 2'b00;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_bcd",   32'(fcIf.bcdOut),    32'h0);
    check("reset_ovf",   32'(fcIf.overflow),  32'h0);
    check("reset_dv",    32'(fcIf.dataValid), 32'h0);
    check("reset_state", 32'(fcIf.state),     32'h0);
    $display("reset: bcd=%04h ovf=%0b state=%0d", fcIf.bcdOut, fcIf.overflow, fcIf.state);

    // Table-driven count/latch scenarios
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].doClear) doClear();
      fcIf.testMode = vecs[v].mode;
      tick(2);
      fcIf.enable = 1'b1;
      tick(2);
      pulses(vecs[v].pulses, vecs[v].halfPer);
      tick(4);
      fcIf.enable = 1'b0;
      tick(2);
      doLatch(3, dv);
      check($sformatf("vec%0d_bcd", v),   32'(fcIf.bcdOut),   32'(vecs[v].expBcd));
      check($sformatf("vec%0d_ovf", v),   32'(fcIf.overflow), 32'(vecs[v].expOvf));
      check($sformatf("vec%0d_state", v), 32'(fcIf.state),    32'h2);
      check($sformatf("vec%0d_dv", v),    32'(dv),            32'd1);
      $display("vec%0d: mode=%0d pulses=%0d bcd=%04h ovf=%0b dv=%0d",
               v, vecs[v].mode, vecs[v].pulses, fcIf.bcdOut, fcIf.overflow, dv);
    end

    // Clear and latch rise on the same edge; latch then held high for 10 cycles
    doClear();
    fcIf.testMode = 2'b00;
    tick(1);
    fcIf.enable = 1'b1;
    tick(2);
    pulses(42, 2);
    tick(4);
    fcIf.clear  = 1'b1;
    fcIf.enable = 1'b0;
    fcIf.latch  = 1'b1;
    dv = 0;
    tick(1);
    if (fcIf.dataValid) dv++;
    fcIf.clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (fcIf.dataValid) dv++;
    end
    check("simul_bcd",   32'(fcIf.bcdOut), 32'h0042);
    check("simul_state", 32'(fcIf.state),  32'h0);
    check("simul_dv",    32'(dv),          32'd1);
    fcIf.latch = 1'b0;
    tick(2);
    doLatch(2, dv);
    check("simul_zero", 32'(fcIf.bcdOut), 32'h0000);
    $display("simul: bcd=%04h state=%0d", fcIf.bcdOut, fcIf.state);

    // Pulses during HOLD must be ignored
    doClear();
    tick(1);
    fcIf.enable = 1'b1;
    tick(2);
    pulses(5, 4);
    tick(4);
    fcIf.enable = 1'b0;
    tick(2);
    pulses(5, 4);
    tick(4);
    doLatch(2, dv);
    check("hold_bcd",   32'(fcIf.bcdOut), 32'h0005);
    check("hold_state", 32'(fcIf.state),  32'h2);
    $display("hold: bcd=%04h state=%0d", fcIf.bcdOut, fcIf.state);

    // Reset mid-count, with a coincident latch rise that must be discarded
    fcIf.enable = 1'b1;
    tick(2);
    pulses(7, 4);
    reset      = 1'b1;
    fcIf.latch = 1'b1;
    tick(1);
    check("rst_bcd",   32'(fcIf.bcdOut),    32'h0);
    check("rst_ovf",   32'(fcIf.overflow),  32'h0);
    check("rst_dv",    32'(fcIf.dataValid), 32'h0);
    check("rst_state", 32'(fcIf.state),     32'h0);
    reset      = 1'b0;
    fcIf.latch = 1'b0;
    tick(3);
    pulses(3, 4);
    tick(4);
    fcIf.enable = 1'b0;
    tick(2);
    doLatch(2, dv);
    check("rst_resume", 32'(fcIf.bcdOut), 32'h0003);
    $display("reset_mid: bcd=%04h state=%0d", fcIf.bcdOut, fcIf.state);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_count_latch.md
FREQ_COUNT_LATCH -- requirements
Module: freq_count_latch

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high; all state SHALL change only on the rising clock edge.
REQ-002 clkControl  input  1  system clock; sole clock of the block.
REQ-003 reset  input  1  synchronous, active-high; initialises all registers on the next clkControl rising edge.
REQ-004 sigIn  input  1  signal under test, asynchronous to clkControl.
REQ-005 enable  input  1  gate window; 1 = count qualified edges.
REQ-006 clear  input  1  1 = zero the running count, prescaler and overflow.
REQ-007 latch  input  1  a 0->1 transition copies the running count to the outputs.
REQ-008 testMode  input  2  prescale select: 00 = /1, 01 = /10, 10 = /100, 11 = /1000.
REQ-009 bcdOut  output  16  latched 4-digit BCD result; [15:12] is the most significant digit.
REQ-010 overflow  output  1  latched overflow flag that travels with bcdOut.
REQ-011 dataValid  output  1  one-cycle pulse when bcdOut and overflow update.
REQ-012 state  output  2  FSM state: 00 = IDLE, 01 = COUNTING, 10 = HOLD.

Function
REQ-013 sigIn SHALL pass through a 2-flop synchroniser; a rising edge SHALL be detected from the 2nd and 3rd flop stages.
- Latency: sigIn edge to counted edge is 3 clkControl cycles.
REQ-014 Detected edges SHALL drive a decade prescaler (0..999) with terminal count 1, 10, 100 or 1000 per testMode.
- Each terminal count SHALL issue one increment to the BCD counter and return the prescaler to 0.
REQ-015 A change of testMode SHALL reset the prescaler to 0 in the same cycle; the running BCD count SHALL be kept.
REQ-016 The running count SHALL be a 4-digit BCD counter.
- Each digit counts 0..9 with carry into the next digit.
- Binary values 10..15 SHALL never appear in any digit.
REQ-017 Overflow: an increment at 9999 SHALL leave the count at 9999 (saturate) and set a sticky internal overflow flag.
- The flag SHALL stay set until clear or reset.
REQ-018 Increments and prescaler advances SHALL occur only in COUNTING with clear = 0.
REQ-019 clear = 1 SHALL, on the same edge, zero the count, prescaler and internal overflow, and force IDLE.
- clear SHALL take priority over enable and over counting.
REQ-020 Latch edge detection SHALL compare latch against its registered value.
- Each 0->1 transition SHALL load bcdOut/overflow from the pre-edge running values and pulse dataValid high for exactly one cycle.
- Holding latch high SHALL produce no further pulses.
REQ-021 A latch edge together with clear SHALL capture the count as it stood before the clear.
REQ-022 A latch edge together with a counting increment SHALL capture the value before the increment; the increment still applies to the running count.
REQ-023 FSM transitions:
- IDLE -> COUNTING when enable = 1.
- COUNTING -> HOLD when enable = 0.
- HOLD -> COUNTING when enable = 1; the count continues and is not restarted.
- Any state -> IDLE when clear = 1.
REQ-024 In HOLD, the running count SHALL be frozen and edges on sigIn SHALL be ignored.
- The prescaler residue SHALL be kept.
REQ-025 bcdOut and overflow SHALL change only on a latch edge or on reset.
- clear SHALL NOT modify them.

Reset
REQ-026 reset = 1 SHALL produce, on the next edge:
- bcdOut = 16'h0000, overflow = 0, dataValid = 0, state = IDLE.
- Count = 0, prescaler = 0, synchroniser flops = 0, registered latch = 0.
REQ-027 reset SHALL take priority over clear, latch and enable.
- A latch edge coincident with reset SHALL be discarded.
REQ-028 reset asserted mid-window SHALL discard the running count; counting SHALL resume only after reset = 0 and enable = 1.

Verification
REQ-029 Basic count: reset, then clear 1 cycle, testMode = 00, enable = 1, apply 37 sigIn pulses (each 4 cycles high, 4 cycles low), enable = 0, latch 0->1.
- Required: bcdOut = 16'h0037, overflow = 0, dataValid high for 1 cycle, state = HOLD.
REQ-030 Prescale: testMode = 01, 1234 pulses, then latch.
- Required: bcdOut = 16'h0123; after a further 6 pulses and latch, bcdOut = 16'h0124 (residue 4 + 6 = 10).
REQ-031 Overflow: testMode = 00, 10005 pulses, latch.
- Required: bcdOut = 16'h9999, overflow = 1.
- Then clear and latch; required: bcdOut = 16'h0000, overflow = 0.
REQ-032 Simultaneous events: with count = 0042, assert clear and a latch rise in the same cycle.
- Required: bcdOut = 16'h0042, running count = 0, state = IDLE.
- Holding latch high for 10 cycles SHALL produce exactly one dataValid pulse.
REQ-033 Hold and reset:
- With enable = 0 after 5 pulses, apply 5 more pulses, then latch; required: 16'h0005.
- Assert reset mid-count; required: all outputs at their REQ-026 values on the next edge.
